// File: rtl/reg_file_sb_if.sv
// Write-back bus into the register file: destination write plus the return-address update.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
);
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ret_we;
  logic [DATA_W-1:0] ret_data;

  modport master (output wb_we, wb_addr, wb_data, ret_we, ret_data);
  modport slave  (input  wb_we, wb_addr, wb_data, ret_we, ret_data);
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard and RAW stall to decode.
// Define WB_BYPASS_EN to forward the final in-flight WB write straight to the read ports.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_a,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_dst,
  output logic              stall,
  reg_file_sb_if.slave      wb,
  output logic [DATA_W-1:0] ret_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs     [NREG];
  logic [CNT_W-1:0]  pcnt     [NREG];
  logic [CNT_W-1:0]  pcnt_nxt [NREG];
  logic              wb_hit, byp_a, byp_b, haz_a, haz_b, sat, issue_acc;

  assign wb_hit = wb.wb_we && (wb.wb_addr != '0);

`ifdef WB_BYPASS_EN
  // A bypass is only safe when the write in flight is the last outstanding producer.
  assign byp_a = rd_en_a && wb_hit && (wb.wb_addr == rd_addr_a) && (pcnt[rd_addr_a] == CNT_W'(1));
  assign byp_b = rd_en_b && wb_hit && (wb.wb_addr == rd_addr_b) && (pcnt[rd_addr_b] == CNT_W'(1));
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign haz_a     = rd_en_a && (pcnt[rd_addr_a] != '0) && !byp_a;
  assign haz_b     = rd_en_b && (pcnt[rd_addr_b] != '0) && !byp_b;
  assign sat       = issue_valid && issue_we && (pcnt[issue_dst] == CNT_MAX);
  assign stall     = haz_a || haz_b || sat;
  assign issue_acc = issue_valid && issue_we && !stall && (issue_dst != '0);

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0)
      rd_data_a = '0;
    else if (byp_a)
      rd_data_a = wb.wb_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0)
      rd_data_b = '0;
    else if (byp_b)
      rd_data_b = wb.wb_data;
  end

  // Simultaneous inc and dec cancel; a dec at zero is a protocol error and is absorbed.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pcnt_nxt[i] = pcnt[i];
      if (issue_acc && (issue_dst == AW'(i)) && !(wb_hit && (wb.wb_addr == AW'(i))))
        pcnt_nxt[i] = pcnt[i] + CNT_W'(1);
      else if (wb_hit && (wb.wb_addr == AW'(i)) && !(issue_acc && (issue_dst == AW'(i)))
               && (pcnt[i] != '0))
        pcnt_nxt[i] = pcnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pcnt[i] <= '0;
      end
      ret_addr <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        pcnt[i] <= pcnt_nxt[i];
      if (wb_hit)
        regs[wb.wb_addr] <= wb.wb_data;
      if (wb.ret_we)
        ret_addr <= wb.ret_data;
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Register file and write-back consumer for the 16-bit core.
- Decode reads two source operands; the WB stage writes the destination register and the next return PC.
- A per-register pending-write scoreboard tracks in-flight producers and raises a stall to decode on RAW hazards.
- Sits between decode/issue and WB; it is the read end of the WB write interface.

Parameters:
- DATA_W, 16, register and data width
- NREG, 16, number of general registers; addresses are log2(NREG) = 4 bits
- CNT_W, 2, width of each per-register pending counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en_a  in  1  operand A is used by the instruction in decode
- rd_addr_a  in  4  operand A register index
- rd_data_a  out  16  operand A value
- rd_en_b  in  1  operand B is used
- rd_addr_b  in  4  operand B register index
- rd_data_b  out  16  operand B value
- issue_valid  in  1  decode issues an instruction this cycle
- issue_we  in  1  issued instruction will write a register
- issue_dst  in  4  destination index of the issued instruction
- stall  out  1  decode must hold; the issue is not accepted
- wb_we  in  1  WB write strobe
- wb_addr  in  4  WB destination index
- wb_data  in  16  WB data
- ret_we  in  1  WB updates the return-address register
- ret_data  in  16  next return PC from WB
- ret_addr  out  16  current return-address register

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset:
  - All registers, ret_addr and every pending counter clear to 0.
  - stall = 0.
  - rd_data_a/b = 0 while the array is zero.
  - Deassertion is synchronous to clk; a reset mid-operation discards all pending state.
- Register 0:
  - Reads always return 0.
  - WB writes to index 0 are ignored.
  - An issue with dst 0 never increments its counter.
- Reads: combinational from the array, zero-cycle latency. The optional bypass below modifies this.
- Writes: on the rising edge where wb_we = 1 and wb_addr != 0, reg[wb_addr] <= wb_data.
- Return address: on the rising edge where ret_we = 1, ret_addr <= ret_data. ret_we is independent of wb_we; both may fire in the same cycle.
- Pending counters, pcnt[i] of CNT_W bits:
  - Increment (inc): an issue is accepted (issue_valid & issue_we & !stall & issue_dst != 0).
  - Decrement (dec): wb_we & wb_addr != 0 at that index.
  - inc and dec on the same index in the same cycle leave the counter unchanged.
  - A dec when the counter is 0 is a protocol error: the counter stays 0 (no underflow).
- stall is combinational and asserts if any of these holds:
  - rd_en_a & pcnt[rd_addr_a] != 0 and no bypass hit on A (see below).
  - The same condition for B.
  - issue_valid & issue_we & pcnt[issue_dst] == 2^CNT_W - 1 (counter saturated).
- A stalled issue changes no counter. Decode holds its inputs stable and retries next cycle.
- Bypass hit on A: rd_en_a & wb_we & wb_addr == rd_addr_a & rd_addr_a != 0 & pcnt[rd_addr_a] == 1, i.e. the last outstanding producer is writing now.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - On a bypass hit, rd_data_x = wb_data in the same cycle and that operand does not stall.
  - The read-after-write penalty is 0 cycles.
- Undefined:
  - No forwarding; bypass hits never occur.
  - A read of a pending register stalls until the cycle after the final WB write, then reads the array.
  - Penalty is 1 extra cycle versus the bypass build.

Test Plan:
- Reset check: assert rst_n = 0 asynchronously mid-cycle -> ret_addr = 0, stall = 0, rd_data_a = 0 for every index, all counters 0.
- Basic write/read: wb_we = 1, wb_addr = 3, wb_data = 16'hBEEF for one edge; next cycle rd_addr_a = 3 -> rd_data_a = 16'hBEEF, stall = 0.
- R0 immunity: wb_we = 1, wb_addr = 0, wb_data = 16'h1234, then read index 0 -> rd_data = 0. Issue with dst 0 -> no stall on a later read of 0.
- RAW hazard: issue dst 5, then rd_en_a = 1, rd_addr_a = 5 -> stall = 1 until WB.
  - WB_BYPASS_EN: in the WB cycle (wb_data = 16'h00A5), stall = 0 and rd_data_a = 16'h00A5.
  - Without WB_BYPASS_EN: stall = 1 in that cycle, 0 the next, and rd_data_a = 16'h00A5.
- Counter saturation: issue dst 7 three times with no WB -> the fourth issue sees stall = 1. One WB to 7 with no read of 7 and no simultaneous issue -> counter 2, issue accepted. Same-cycle issue dst 7 plus WB to 7 -> counter unchanged.
- Return address: ret_we = 1, ret_data = 16'h0042 with wb_we = 1, wb_addr = 2 on the same edge -> ret_addr = 16'h0042 and reg[2] updated; ret_we = 0 next -> ret_addr holds 16'h0042.
